serial_comparator: RTL and testbench
====================================

# serial_comparator

Multi-cycle, parametrised magnitude comparator that resolves two N-bit operands MSB-first, W bits per clock, with early termination on the first differing chunk. It supports unsigned and two's-complement modes, and uses a start/busy/done handshake. It replaces the single-cycle combinational N-bit comparator in datapaths where wide operands would otherwise limit fmax. It sits between an operand source and a consumer that samples the result on `done`.

## Interface
- `N`, default 8: operand width. Must be ≥ 2.
- `W`, default 2: bits compared per cycle. 1 ≤ W ≤ N; N % W == 0 is required and checked at elaboration.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: reset, asynchronous assert, active-low.
- `start` in 1: request a compare. Sampled only when the block is accepting.
- `signed_mode` in 1: 1 = two's complement, 0 = unsigned. Captured with `start`.
- `a` in N: operand A, captured with `start`.
- `b` in N: operand B, captured with `start`.
- `busy` out 1: high while a compare is in progress (CMP state).
- `done` out 1: one-cycle pulse; result valid and newly updated.
- `ls` out 1: A < B.
- `gr` out 1: A > B.
- `eq` out 1: A == B.

## Operation
- States: IDLE, CMP, DONE. Reset state is IDLE.
- Acceptance: `start` is accepted in IDLE or DONE, and ignored in CMP.
  - On accept: latch `a`, `b` and `signed_mode` into shift registers, clear the chunk counter, go to CMP.
- CMP, each cycle: compare the top W bits of the A and B shift registers as an unsigned W-bit chunk.
  - Signed mode, chunk 0 only: invert the MSB of both chunks before comparing. This maps two's-complement order to unsigned order.
  - Chunks differ: record lt/gt, go to DONE (early termination).
  - Chunks equal, counter == N/W−1: record eq, go to DONE.
  - Otherwise: shift both registers left by W and increment the counter.
- DONE, one cycle: `done`=1, with `ls`/`gr`/`eq` updated this cycle. Next state is IDLE, or CMP if `start` is asserted.
- Result outputs:
  - After the first completion they are always one-hot.
  - They hold their value until the next `done`; they do not change during CMP.
- Counter width: $clog2(N/W), minimum 1 bit. Counter value never exceeds N/W−1.
- Reset mid-compare: returns to IDLE immediately, clears all outputs, no `done` pulse, captured operands discarded.

## Timing
- Reset values: `busy`=0, `done`=0, `ls`=0, `gr`=0, `eq`=0, state=IDLE.
- Cycle numbering: `start` accepted at edge 0; CMP occupies cycles 1..k+1, where k is the index of the deciding chunk (MSB chunk = 0).
- `done` is high in cycle k+2.
- Latency: best case 2 cycles; worst case (equal, or last-chunk difference) N/W+1 cycles.
- Throughput: back-to-back `start` in the DONE cycle gives one result every k+2 cycles with no idle gap.
- `busy` is low in IDLE and DONE, high in CMP.
- `a`, `b` and `signed_mode` may change freely after the accept edge.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Structure
- Shared package `comparator_pkg` contains:
  - `cmp_state_t` enum {IDLE, CMP, DONE}.
  - `cmp_result_t` packed struct {ls, gr, eq}.
  - localparam helper for the chunk count.
- Sub-module `chunk_compare`: parametrised W-bit combinational unsigned compare with outputs lt/gt/eq. It is instantiated once.
- Top level: FSM, operand shift registers, counter, sign-fix logic on chunk 0, and result registers.

## Test plan
- Reset and idle:
  - Assert `rst_n`=0 mid-simulation → all outputs 0 asynchronously.
  - No `start` for 10 cycles after release → `done` never pulses.
- Unsigned, early exit (N=8, W=2): a=8'h80, b=8'h7F, signed_mode=0 → `gr`=1, `ls`=0, `eq`=0, `done` at cycle 2.
- Signed, same operands: a=8'h80, b=8'h7F, signed_mode=1 → `ls`=1 (−128 < 127), `done` at cycle 2.
- Full-length compares:
  - a=b=8'h5A → `eq`=1, `done` at cycle 5.
  - a=8'h5A, b=8'h5B → `ls`=1, `done` at cycle 5.
  - Signed a=8'hFF, b=8'hFE → `gr`=1 (−1 > −2), `done` at cycle 5.
- Handshake edges:
  - `start` held high during CMP → ignored; exactly one `done`.
  - `start` in the DONE cycle with a=3, b=3 → second `done` with `eq`=1 at cycle 5 after that start; first result held until then.
  - `rst_n` pulsed low during CMP → no `done`, outputs 0.
- Random regression, N ∈ {8,16,32}, W ∈ {1,2,4,8}: random operands and mode. Check:
  - result against a behavioural compare;
  - one-hot results;
  - latency equals the deciding chunk index + 2.

Source files
------------

// File: rtl/comparator_pkg.sv
// Shared types and sizing helpers for the MSB-first serial magnitude comparator.
package comparator_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMP  = 2'd1,
        DONE = 2'd2
    } cmp_state_t;

    typedef struct packed {
        logic ls;
        logic gr;
        logic eq;
    } cmp_result_t;

    function automatic int chunk_count(input int n, input int w);
        return n / w;
    endfunction

    // A single-chunk configuration still needs a 1-bit counter.
    function automatic int count_width(input int n, input int w);
        return (n / w > 1) ? $clog2(n / w) : 1;
    endfunction

endpackage

// File: rtl/serial_comparator_if.sv
// Operand/result bundle for serial_comparator.
// Handshake: start is taken on a rising edge only when busy is low; done pulses for one
// cycle when ls/gr/eq are refreshed, and those outputs hold until the next done.
interface serial_comparator_if #(
    parameter int N = 8
);
    logic         start;
    logic         signed_mode;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         busy;
    logic         done;
    logic         ls;
    logic         gr;
    logic         eq;

    modport master (output start, signed_mode, a, b, input busy, done, ls, gr, eq);
    modport slave  (input start, signed_mode, a, b, output busy, done, ls, gr, eq);
endinterface

// File: rtl/chunk_compare.sv
// Combinational unsigned compare of one W-bit chunk.
module chunk_compare #(
    parameter int W = 2
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         lt,
    output logic         gt,
    output logic         eq
);

    assign lt = (a < b);
    assign gt = (a > b);
    assign eq = (a == b);

endmodule

// File: rtl/serial_comparator.sv
// Multi-cycle N-bit magnitude comparator: resolves W bits per clock from the MSB end and
// stops on the first differing chunk. Unsigned or two's-complement per request.
module serial_comparator
    import comparator_pkg::*;
#(
    parameter int N = 8,
    parameter int W = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    serial_comparator_if.slave      cmp,
    output cmp_state_t              state_dbg
);

    localparam int              NC        = chunk_count(N, W);
    localparam int              CW        = count_width(N, W);
    localparam logic [CW-1:0]   LAST      = CW'(NC - 1);
    localparam logic [W-1:0]    SIGN_MASK = W'(1) << (W - 1);

    if (N < 2 || W < 1 || W > N || (N % W) != 0) begin : g_bad_params
        $error("serial_comparator: N=%0d must be >= 2 and a multiple of W=%0d", N, W);
    end

    cmp_state_t    state;
    logic [N-1:0]  a_sh;
    logic [N-1:0]  b_sh;
    logic          signed_q;
    logic [CW-1:0] cnt;
    logic          busy_q;
    logic          done_q;
    cmp_result_t   res_q;

    logic [W-1:0]  a_chunk;
    logic [W-1:0]  b_chunk;
    logic          c_lt;
    logic          c_gt;
    logic          c_eq;

    // Flipping the sign bit of the top chunk turns two's-complement order into unsigned order.
    assign a_chunk = a_sh[N-1 -: W] ^ ((signed_q && cnt == '0) ? SIGN_MASK : '0);
    assign b_chunk = b_sh[N-1 -: W] ^ ((signed_q && cnt == '0) ? SIGN_MASK : '0);

    chunk_compare #(.W(W)) u_chunk (
        .a  (a_chunk),
        .b  (b_chunk),
        .lt (c_lt),
        .gt (c_gt),
        .eq (c_eq)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            a_sh     <= '0;
            b_sh     <= '0;
            signed_q <= 1'b0;
            cnt      <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            res_q    <= '0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (cmp.start) begin
                        a_sh     <= cmp.a;
                        b_sh     <= cmp.b;
                        signed_q <= cmp.signed_mode;
                        cnt      <= '0;
                        busy_q   <= 1'b1;
                        state    <= CMP;
                    end else begin
                        state <= IDLE;
                    end
                end
                CMP: begin
                    if (!c_eq) begin
                        res_q  <= '{ls: c_lt, gr: c_gt, eq: 1'b0};
                        done_q <= 1'b1;
                        busy_q <= 1'b0;
                        state  <= DONE;
                    end else if (cnt == LAST) begin
                        res_q  <= '{ls: 1'b0, gr: 1'b0, eq: 1'b1};
                        done_q <= 1'b1;
                        busy_q <= 1'b0;
                        state  <= DONE;
                    end else begin
                        a_sh <= a_sh << W;
                        b_sh <= b_sh << W;
                        cnt  <= cnt + CW'(1);
                    end
                end
                default: begin
                    busy_q <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

    assign cmp.busy  = busy_q;
    assign cmp.done  = done_q;
    assign cmp.ls    = res_q.ls;
    assign cmp.gr    = res_q.gr;
    assign cmp.eq    = res_q.eq;
    assign state_dbg = state;

endmodule

// File: tb/tb_serial_comparator.sv
// Bench for serial_comparator: directed N=8/W=2 cases plus randomized traffic on several
// N/W configurations, scored against an arithmetic reference model.
module tb_serial_comparator;
    import comparator_pkg::*;

    localparam int EXP_W  = 35;  // {start_cycle[15:0], done_cycle[15:0], ls, gr, eq}
    localparam int NR     = 8;
    localparam int RND_TX = 40;
    localparam int CFG_N [NR] = '{8, 8, 8, 16, 16, 32, 32, 32};
    localparam int CFG_W [NR] = '{1, 4, 8, 1, 8, 2, 4, 8};

    logic clk;
    logic rst_n;
    logic rst_n_r;
    int   cyc = 0;
    int   tests = 0;
    int   fails = 0;
    int   m_dones = 0;
    int   rnd_done = 0;

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- reference model ----------------
    function automatic logic [2:0] ref_res(input int n, input logic [31:0] a, input logic [31:0] b,
                                           input bit sm);
        longint va;
        longint vb;
        va = longint'(a);
        vb = longint'(b);
        if (sm && a[n-1]) va = va - (longint'(1) << n);
        if (sm && b[n-1]) vb = vb - (longint'(1) << n);
        return {va < vb, va > vb, va == vb};
    endfunction

    // Deciding chunk: the one holding the highest differing bit, or the last chunk if equal.
    function automatic int ref_k(input int n, input int w, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] x;
        int p;
        x = a ^ b;
        p = -1;
        for (int i = 0; i < n; i++) if (x[i]) p = i;
        return (p < 0) ? (n / w - 1) : ((n - 1 - p) / w);
    endfunction

    function automatic logic [EXP_W-1:0] mk_exp(input int n, input int w, input logic [31:0] a,
                                                input logic [31:0] b, input bit sm, input int c);
        int d;
        d = c + ref_k(n, w, a, b) + 2;
        return {16'(c), 16'(d), ref_res(n, a, b, sm)};
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // ---------------- main DUT (N=8, W=2) ----------------
    serial_comparator_if #(.N(8)) m_if ();
    cmp_state_t       state_m;
    logic [EXP_W-1:0] exp_m[$];
    logic [2:0]       held_m = 3'b000;

    serial_comparator #(.N(8), .W(2)) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmp       (m_if),
        .state_dbg (state_m)
    );

    // scoreboard monitor: results on done, held outputs and busy otherwise
    always @(negedge clk) begin
        logic [EXP_W-1:0] e;
        logic             exp_busy;
        if (!rst_n) begin
            held_m = 3'b000;
        end else if (m_if.done) begin
            m_dones++;
            if (exp_m.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL main_unexpected_done: got done=1 at cycle %0d, required no pending result", cyc);
            end else begin
                e = exp_m.pop_front();
                check("main_result", 32'({m_if.busy, m_if.ls, m_if.gr, m_if.eq}), 32'({1'b0, e[2:0]}));
                check("main_latency", 32'(cyc[15:0]), 32'(e[18:3]));
                check("main_onehot", 32'($onehot({m_if.ls, m_if.gr, m_if.eq})), 32'd1);
                held_m = e[2:0];
            end
        end else begin
            exp_busy = (exp_m.size() > 0) && (cyc[15:0] > exp_m[0][34:19]);
            check("main_hold", 32'({m_if.busy, m_if.ls, m_if.gr, m_if.eq}), 32'({exp_busy, held_m}));
        end
    end

    // ---------------- driver tasks ----------------
    task automatic issue_m(input logic [7:0] a, input logic [7:0] b, input bit sm);
        m_if.a           = a;
        m_if.b           = b;
        m_if.signed_mode = sm;
        m_if.start       = 1'b1;
        exp_m.push_back(mk_exp(8, 2, 32'(a), 32'(b), sm, cyc));
        @(negedge clk);
        m_if.start       = 1'b0;
        m_if.a           = 8'($urandom());
        m_if.b           = 8'($urandom());
        m_if.signed_mode = 1'($urandom());
    endtask

    task automatic wait_done_m(input string name);
        int t;
        t = 0;
        while (!m_if.done && t < 20) begin
            @(negedge clk);
            t++;
        end
        if (!m_if.done) begin
            tests++;
            fails++;
            $display("FAIL %s_timeout: got no done in 20 cycles, required done", name);
        end
    endtask

    task automatic reset_and_check(input string name);
        #2 rst_n = 1'b0;
        exp_m.delete();
        held_m = 3'b000;
        #1;
        check({name, "_outputs"}, 32'({m_if.busy, m_if.done, m_if.ls, m_if.gr, m_if.eq}), 32'd0);
        check({name, "_state"}, 32'(state_m), 32'(IDLE));
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // ---------------- randomized configurations ----------------
    for (genvar g = 0; g < NR; g++) begin : g_rnd
        localparam int GN = CFG_N[g];
        localparam int GW = CFG_W[g];
        serial_comparator_if #(.N(GN)) r_if ();
        cmp_state_t       r_state;
        logic [EXP_W-1:0] r_q[$];

        serial_comparator #(.N(GN), .W(GW)) u_dut (
            .clk       (clk),
            .rst_n     (rst_n_r),
            .cmp       (r_if),
            .state_dbg (r_state)
        );

        always @(negedge clk) begin
            logic [EXP_W-1:0] e;
            if (rst_n_r && r_if.done) begin
                if (r_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL rnd_n%0d_w%0d_unexpected_done: got done=1, required no pending result", GN, GW);
                end else begin
                    e = r_q.pop_front();
                    check($sformatf("rnd_n%0d_w%0d_result", GN, GW),
                          32'({r_if.busy, r_if.ls, r_if.gr, r_if.eq}), 32'({1'b0, e[2:0]}));
                    check($sformatf("rnd_n%0d_w%0d_latency", GN, GW), 32'(cyc[15:0]), 32'(e[18:3]));
                    check($sformatf("rnd_n%0d_w%0d_onehot", GN, GW),
                          32'($onehot({r_if.ls, r_if.gr, r_if.eq})), 32'd1);
                end
            end
        end

        initial begin
            logic [GN-1:0] ra;
            logic [GN-1:0] rb;
            bit            sm;
            int            to;
            r_if.start       = 1'b0;
            r_if.signed_mode = 1'b0;
            r_if.a           = '0;
            r_if.b           = '0;
            wait (rst_n_r === 1'b1);
            @(negedge clk);
            for (int t = 0; t < RND_TX; t++) begin
                ra = GN'($urandom());
                case ($urandom_range(0, 3))
                    0:       rb = ra;
                    1:       rb = ra ^ (GN'(1) << $urandom_range(0, GN - 1));
                    default: rb = GN'($urandom());
                endcase
                sm               = 1'($urandom());
                r_if.a           = ra;
                r_if.b           = rb;
                r_if.signed_mode = sm;
                r_if.start       = 1'b1;
                r_q.push_back(mk_exp(GN, GW, 32'(ra), 32'(rb), sm, cyc));
                @(negedge clk);
                r_if.start = 1'b0;
                r_if.a     = GN'($urandom());
                r_if.b     = GN'($urandom());
                to = 0;
                while (!r_if.done && to < GN + 8) begin
                    @(negedge clk);
                    to++;
                end
                if (!r_if.done) begin
                    tests++;
                    fails++;
                    $display("FAIL rnd_n%0d_w%0d_timeout: got no done, required done", GN, GW);
                end
                if ($urandom_range(0, 2) != 0) repeat ($urandom_range(1, 2)) @(negedge clk);
            end
            repeat (3) @(negedge clk);
            check($sformatf("rnd_n%0d_w%0d_drained", GN, GW), 32'(r_q.size()), 32'd0);
            check($sformatf("rnd_n%0d_w%0d_idle", GN, GW), 32'(r_state), 32'(IDLE));
            rnd_done++;
        end
    end

    // ---------------- directed sequence and report ----------------
    initial begin
        int d0;
        int t;
        logic [7:0] ra;
        logic [7:0] rb;
        rst_n            = 1'b0;
        rst_n_r          = 1'b0;
        m_if.start       = 1'b0;
        m_if.signed_mode = 1'b0;
        m_if.a           = '0;
        m_if.b           = '0;
        repeat (3) @(negedge clk);
        check("reset_outputs", 32'({m_if.busy, m_if.done, m_if.ls, m_if.gr, m_if.eq}), 32'd0);
        check("reset_state", 32'(state_m), 32'(IDLE));
        rst_n   = 1'b1;
        rst_n_r = 1'b1;

        d0 = m_dones;
        repeat (10) @(negedge clk);
        check("idle_no_done", 32'(m_dones - d0), 32'd0);

        issue_m(8'h80, 8'h7F, 1'b0); wait_done_m("u_early");   @(negedge clk);
        issue_m(8'h80, 8'h7F, 1'b1); wait_done_m("s_early");   @(negedge clk);
        issue_m(8'h5A, 8'h5A, 1'b0); wait_done_m("u_equal");   @(negedge clk);
        issue_m(8'h5A, 8'h5B, 1'b0); wait_done_m("u_lastbit"); @(negedge clk);
        issue_m(8'hFF, 8'hFE, 1'b1); wait_done_m("s_neg");     @(negedge clk);

        // second start lands in the DONE cycle of the first
        issue_m(8'h12, 8'h34, 1'b0); wait_done_m("b2b_first");
        issue_m(8'h03, 8'h03, 1'b0); wait_done_m("b2b_second");
        @(negedge clk);

        // start held through the whole compare with operands wandering
        m_if.a           = 8'hC3;
        m_if.b           = 8'hC3;
        m_if.signed_mode = 1'b1;
        m_if.start       = 1'b1;
        exp_m.push_back(mk_exp(8, 2, 32'h0000_00C3, 32'h0000_00C3, 1'b1, cyc));
        repeat (5) begin
            @(negedge clk);
            m_if.a = 8'($urandom());
            m_if.b = 8'($urandom());
        end
        m_if.start = 1'b0;
        wait_done_m("start_held");
        repeat (3) @(negedge clk);

        reset_and_check("async_reset");
        @(negedge clk);

        issue_m(8'h5A, 8'h5A, 1'b0);
        @(negedge clk);
        reset_and_check("reset_mid_cmp");
        d0 = m_dones;
        repeat (8) @(negedge clk);
        check("reset_no_done", 32'(m_dones - d0), 32'd0);

        for (int i = 0; i < 30; i++) begin
            ra = 8'($urandom());
            case ($urandom_range(0, 3))
                0:       rb = ra;
                1:       rb = ra ^ (8'd1 << $urandom_range(0, 7));
                default: rb = 8'($urandom());
            endcase
            issue_m(ra, rb, 1'($urandom()));
            wait_done_m("main_rnd");
            if ($urandom_range(0, 2) != 0) repeat ($urandom_range(1, 2)) @(negedge clk);
        end
        repeat (3) @(negedge clk);
        check("main_drained", 32'(exp_m.size()), 32'd0);

        t = 0;
        while (rnd_done < NR && t < 20000) begin
            @(negedge clk);
            t++;
        end
        if (rnd_done < NR) begin
            tests++;
            fails++;
            $display("FAIL rnd_finish_timeout: got %0d configurations finished, required %0d", rnd_done, NR);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
